four_input_nor_test_sequencer: RTL and testbench
================================================

FOUR_INPUT_NOR_TEST_SEQUENCER -- requirements
Module: four_input_nor_test_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 2, idle cycles between applying a vector and sampling results (legal range 0..15).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a full 16-vector sweep.
- abort  input  1  cancels a running sweep.
- a, b, c, d  output  1 each  stimulus to the NOR datapath under test.
- e, f, g  input  1 each  datapath results.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; results valid.
- pass  output  1  all 16 vectors matched.
- err_count  output  5  number of failing vectors, 0..16.
- fail_valid  output  1  at least one failure recorded.
- fail_vec  output  4  index of the first failing vector.

Function
REQ-003 Datapath contract: expected f = ~(a|b), g = ~(c|d), e = ~(a|b|c|d); a vector fails if any of e, f or g differs.
REQ-004 The vector counter vec[3:0] SHALL map to a=vec[3], b=vec[2], c=vec[1], d=vec[0]; d toggles fastest.
REQ-005 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-006 IDLE SHALL be held with busy=0; start=1 SHALL clear err_count, fail_valid, fail_vec, pass and done, load vec=0 and enter APPLY.
REQ-007 In APPLY, a..d SHALL be driven from vec for one cycle.
- Next state is SETTLE when SETTLE_CYCLES>0, otherwise CHECK.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles, using an internal counter reloaded on entry, then go to CHECK.
REQ-009 CHECK SHALL last one cycle and compare e, f, g against the expected values.
- On a mismatch, err_count SHALL increment.
- If fail_valid=0, fail_vec<=vec and fail_valid<=1.
REQ-010 After CHECK, vec<15 SHALL increment vec and go to APPLY; vec=15 SHALL go to DONE.
- There is no wrap past 15.
REQ-011 In DONE: done=1, busy=0, and pass=(err_count==0) registered on entry.
- Results SHALL be held until the next start.
- start in DONE SHALL behave as in IDLE, going directly to APPLY with results cleared.
REQ-012 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 otherwise.
REQ-013 a..d SHALL hold the current vector value through APPLY, SETTLE and CHECK, and SHALL be 0 in IDLE.
- In DONE, a..d SHALL hold the last applied vector.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 abort while busy=1 SHALL go to IDLE on the next edge with done=0 and pass=0.
- err_count, fail_valid and fail_vec SHALL hold their partial values.
- abort has priority over the CHECK result update in the same cycle.
- abort in IDLE or DONE SHALL be ignored.
REQ-016 Sweep latency: done SHALL rise 16*(SETTLE_CYCLES+2) edges after the edge that samples start.
- This is 64 edges at the default SETTLE_CYCLES=2.
REQ-017 err_count SHALL never exceed 16; 5 bits covers the range, so no saturation logic is needed.

Reset
REQ-018 rst_n=0 SHALL immediately (asynchronously) force state IDLE, vec=0 and settle counter=0.
- All outputs SHALL be 0: a..d, busy, done, pass, err_count, fail_valid, fail_vec.
REQ-019 Reset asserted mid-sweep SHALL discard all progress.
- After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Correct NOR model, default parameter, start pulse -> done after 64 edges; pass=1, err_count=0, fail_valid=0; a..d step 0000..1111.
- Model with f stuck at 0 -> err_count=4 (vectors 0..3 fail), fail_vec=0, pass=0.
- Model with e wrong only at vec=9 -> err_count=1, fail_valid=1, fail_vec=9, pass=0.
- SETTLE_CYCLES=0 -> done after 32 edges; a second start during busy has no effect on timing.
- abort asserted at vec=5 -> IDLE next edge, busy=0, done=0; a new start then completes a normal 64-edge sweep.
- rst_n pulsed low mid-SETTLE -> all outputs 0 immediately; no activity until the next start.

Source files
------------

// File: rtl/four_input_nor_test_sequencer.sv
// Sweeps all 16 input vectors through an external 4-input NOR datapath and
// checks e/f/g after a programmable settle time, recording error statistics.
module four_input_nor_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

  // Counter counts down to zero, so a settle of N cycles loads N-1.
  localparam logic [3:0] SettleLoad = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       fvld_q, fvld_d;
  logic [3:0] fvec_q, fvec_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic exp_e, exp_f, exp_g, mismatch;

  assign exp_f    = ~(vec_q[3] | vec_q[2]);
  assign exp_g    = ~(vec_q[1] | vec_q[0]);
  assign exp_e    = ~(|vec_q);
  assign mismatch = (e != exp_e) | (f != exp_f) | (g != exp_g);

  assign busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StCheck);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StApply;
          vec_d   = 4'd0;
          err_d   = 5'd0;
          fvld_d  = 1'b0;
          fvec_d  = 4'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StApply: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          state_d = StCheck;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q == 4'd15) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_d == 5'd0);
        end else begin
          state_d = StApply;
          vec_d   = vec_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any CHECK update; partial error results are kept.
    if (busy && abort) begin
      state_d = StIdle;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fvld_d  = fvld_q;
      fvec_d  = fvec_q;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      fvld_q  <= 1'b0;
      fvec_q  <= 4'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Stimulus is parked at zero only while idle; DONE keeps the last vector.
  always_comb begin
    {a, b, c, d} = 4'd0;
    if (state_q != StIdle) begin
      {a, b, c, d} = vec_q;
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvld_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_four_input_nor_test_sequencer.sv
// Bench for the NOR test sequencer: two instances (settle 2 and 0) driving a
// NOR datapath model with injectable per-vector faults.
module tb_four_input_nor_test_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  start_v = 2'b00;
  logic [1:0]  abort_v = 2'b00;
  logic [15:0] fe = 16'd0, ff = 16'd0, fg = 16'd0;

  logic       a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0, fvld0;
  logic [4:0] err0;
  logic [3:0] fvec0, v0;
  logic       a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1, fvld1;
  logic [4:0] err1;
  logic [3:0] fvec1, v1;

  // Datapath model: correct NOR gates with a per-vector inversion mask.
  assign v0 = {a0, b0, c0, d0};
  assign e0 = ~(a0 | b0 | c0 | d0) ^ fe[v0];
  assign f0 = ~(a0 | b0) ^ ff[v0];
  assign g0 = ~(c0 | d0) ^ fg[v0];
  assign v1 = {a1, b1, c1, d1};
  assign e1 = ~(a1 | b1 | c1 | d1) ^ fe[v1];
  assign f1 = ~(a1 | b1) ^ ff[v1];
  assign g1 = ~(c1 | d1) ^ fg[v1];

  four_input_nor_test_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fvld0), .fail_vec(fvec0)
  );

  four_input_nor_test_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fvld1), .fail_vec(fvec1)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic       fvld;
    logic [3:0] fvec;
    logic [3:0] vec;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  function automatic obs_t snap(input int i);
    obs_t o;
    if (i == 0) o = '{busy0, done0, pass0, err0, fvld0, fvec0, v0};
    else        o = '{busy1, done1, pass1, err1, fvld1, fvec1, v1};
    return o;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a vector fails if any of its outputs is corrupted.
  task automatic model(output int err, output int first);
    err   = 0;
    first = -1;
    for (int v = 0; v < 16; v++) begin
      if (fe[v] | ff[v] | fg[v]) begin
        err++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    obs_t o = snap(i);
    check_eq({tag, "_busy"}, int'(o.busy), 0);
    check_eq({tag, "_done"}, int'(o.done), 0);
    check_eq({tag, "_pass"}, int'(o.pass), 0);
    check_eq({tag, "_err"},  int'(o.err),  0);
    check_eq({tag, "_fvld"}, int'(o.fvld), 0);
    check_eq({tag, "_fvec"}, int'(o.fvec), 0);
    check_eq({tag, "_abcd"}, int'(o.vec),  0);
  endtask

  task automatic sweep(input int i, input bit restart_mid);
    int   s   = (i == 0) ? S0 : S1;
    int   lat = 16 * (s + 2);
    int   n   = 0;
    int   err, first;
    obs_t o;
    model(err, first);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    while (!snap(i).done && n < lat + 20) begin
      o = snap(i);
      check_eq("busy_run", int'(o.busy), 1);
      check_eq("abcd_seq", int'(o.vec), (n < lat) ? n / (s + 2) : 15);
      if (restart_mid && n == 7) start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      n++;
    end
    o = snap(i);
    check_eq("latency",    n, lat);
    check_eq("done",       int'(o.done), 1);
    check_eq("busy_done",  int'(o.busy), 0);
    check_eq("pass",       int'(o.pass), (err == 0) ? 1 : 0);
    check_eq("err_count",  int'(o.err), err);
    check_eq("fail_valid", int'(o.fvld), (err > 0) ? 1 : 0);
    check_eq("fail_vec",   int'(o.fvec), (first < 0) ? 0 : first);
    check_eq("abcd_hold",  int'(o.vec), 15);
  endtask

  initial begin
    obs_t o;
    int   n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct datapath, default settle.
    sweep(0, 1'b0);

    // f stuck at 0: corrupted wherever the correct f is 1.
    for (int v = 0; v < 16; v++) ff[v] = ~(v[3] | v[2]);
    sweep(0, 1'b0);
    check_eq("stuck_f_err", int'(err0), 4);
    ff = 16'd0;

    // e wrong only at vector 9.
    fe = 16'd1 << 9;
    sweep(0, 1'b0);
    check_eq("e9_fvec", int'(fvec0), 9);
    fe = 16'd0;

    // Zero settle, extra start while busy must not disturb timing.
    sweep(1, 1'b1);

    // Abort in DONE is ignored.
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    check_eq("abort_done_ignored", int'(done0), 1);

    // Abort at vector 5 with a fault already recorded at vector 2.
    fg = 16'd1 << 2;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (v0 != 4'd5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("abort_reach_vec5", int'(v0), 5);
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    o = snap(0);
    check_eq("abort_busy", int'(o.busy), 0);
    check_eq("abort_done", int'(o.done), 0);
    check_eq("abort_pass", int'(o.pass), 0);
    check_eq("abort_abcd", int'(o.vec),  0);
    check_eq("abort_err",  int'(o.err),  1);
    check_eq("abort_fvld", int'(o.fvld), 1);
    check_eq("abort_fvec", int'(o.fvec), 2);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_stay_idle", int'(busy0), 0);
    fg = 16'd0;
    sweep(0, 1'b0);

    // Reset mid-SETTLE with a recorded failure: everything clears at once.
    fg = 16'd1 << 1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    check_eq("pre_rst_err", int'(err0), 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero(0, "async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_idle_zero(0, "post_rst");
    fg = 16'd0;

    // Randomized fault patterns on either instance.
    for (int k = 0; k < 8; k++) begin
      int i = int'($urandom_range(1, 0));
      fe = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ff = 16'($urandom) & 16'($urandom) & 16'($urandom);
      fg = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        fe = 16'd0;
        ff = 16'd0;
        fg = 16'd0;
      end
      sweep(i, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
